// File: rtl/int_div_iterative_pkg.sv
// int_div_iterative_pkg: shared FSM state type, message field slices and iteration count for the divider
package int_div_iterative_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int W = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);
  localparam int DIVIDEND_HI = 63;
  localparam int DIVIDEND_LO = 32;
  localparam int DIVISOR_HI = 31;
  localparam int DIVISOR_LO = 0;
  localparam int REM_HI = 63;
  localparam int REM_LO = 32;
  localparam int QUO_HI = 31;
  localparam int QUO_LO = 0;
endpackage

// File: rtl/int_div_iterative_dpath.sv
// int_div_iterative_dpath: restoring-division datapath (load/step controls in; in_msg dividend|divisor; out_msg rem|quo; divisor_is_zero, count_done status)
module int_div_iterative_dpath
  import int_div_iterative_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [2*W-1:0]   in_msg,
  output logic [2*W-1:0]   out_msg,
  output logic             divisor_is_zero,
  output logic             count_done
);
  logic [W-1:0] dividend, divisor, dmag, rem, quo, rem_sh, quo_sh, rem_nx, quo_nx;
  logic [W:0] trial;
  logic a_neg, quo_neg;
  logic [CNT_W-1:0] count;
  assign dividend = in_msg[DIVIDEND_HI:DIVIDEND_LO];
  assign divisor = in_msg[DIVISOR_HI:DIVISOR_LO];
  assign divisor_is_zero = divisor == '0;
  assign count_done = count == CNT_W'(ITERS - 1);
  assign {rem_sh, quo_sh} = {rem, quo} << 1;
  assign trial = {1'b0, rem_sh} - {1'b0, dmag};
  assign rem_nx = trial[W] ? rem_sh : trial[W-1:0];
  assign quo_nx = {quo_sh[W-1:1], ~trial[W]};
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      out_msg <= '0;
      rem <= '0;
      quo <= '0;
      dmag <= '0;
      a_neg <= 1'b0;
      quo_neg <= 1'b0;
    end else if (load) begin
      a_neg <= dividend[W-1];
      quo_neg <= dividend[W-1] ^ divisor[W-1];
      dmag <= divisor[W-1] ? -divisor : divisor;
      quo <= dividend[W-1] ? -dividend : dividend;
      rem <= '0;
      count <= '0;
      if (divisor_is_zero) out_msg <= {dividend, {W{1'b1}}};
    end else if (step) begin
      rem <= rem_nx;
      quo <= quo_nx;
      count <= count + CNT_W'(1);
      if (count_done) begin
        out_msg[REM_HI:REM_LO] <= a_neg ? -rem_nx : rem_nx;
        out_msg[QUO_HI:QUO_LO] <= quo_neg ? -quo_nx : quo_nx;
      end
    end
  end
endmodule

// File: rtl/int_div_iterative.sv
// int_div_iterative: signed 32-bit val/rdy iterative divider (istream {dividend,divisor} in, ostream {remainder,quotient} out, clk/reset sync active-high)
module int_div_iterative
  import int_div_iterative_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [2*W-1:0]   istream_msg,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [2*W-1:0]   ostream_msg
);
  state_t state, state_d;
  logic load, divisor_is_zero, count_done;
  assign istream_rdy = (state == IDLE) && !reset;
  assign ostream_val = state == DONE;
  assign load = istream_val && istream_rdy;
  always_ff @(posedge clk) state <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (load ? (divisor_is_zero ? DONE : CALC) : IDLE)
            : state == CALC ? (count_done ? DONE : CALC)
            : (ostream_rdy ? IDLE : DONE);
  end
  int_div_iterative_dpath u_dpath (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .step            (state == CALC),
    .in_msg          (istream_msg),
    .out_msg         (ostream_msg),
    .divisor_is_zero (divisor_is_zero),
    .count_done      (count_done)
  );
  function automatic string line_trace();
    return $sformatf("%s%h|%s%02d|%s%h",
      load ? "#" : " ", istream_msg, state.name(), u_dpath.count,
      (ostream_val && ostream_rdy) ? "#" : " ", ostream_msg);
  endfunction
endmodule

// File: tb/tb_int_div_iterative.sv
// tb_int_div_iterative: self-checking bench with directed corners and random stream against an arithmetic reference
module tb_int_div_iterative;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic istream_val = 1'b0;
  logic istream_rdy;
  logic [63:0] istream_msg = '0;
  logic ostream_val;
  logic ostream_rdy = 1'b0;
  logic [63:0] ostream_msg;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  int_div_iterative dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );
  function automatic logic [63:0] model(input logic [63:0] m);
    int a, b;
    a = m[63:32];
    b = m[31:0];
    if (b == 0) return {m[63:32], 32'hFFFFFFFF};
    if (a == int'(32'h80000000) && b == -1) return {32'h0, 32'h80000000};
    return {32'(a % b), 32'(a / b)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [63:0] msg);
    int t = 0;
    while (!istream_rdy && t < 200) begin @(posedge clk); #1; t++; end
    chk("send_rdy", 64'(istream_rdy), 64'd1);
    istream_val = 1'b1;
    istream_msg = msg;
    @(posedge clk); #1;
    istream_val = 1'b0;
  endtask
  task automatic wait_val(output int lat);
    lat = 1;
    while (!ostream_val && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic recv(output logic [63:0] got, output int lat);
    wait_val(lat);
    got = ostream_msg;
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    ostream_rdy = 1'b0;
  endtask
  task automatic txn(input string tag, input logic [63:0] msg, input logic [63:0] exp, input int exp_lat);
    logic [63:0] got;
    int lat;
    send(msg);
    recv(got, lat);
    chk(tag, got, exp);
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask
  initial begin
    logic [63:0] got, held, m;
    logic stable;
    int lat;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irdy", 64'(istream_rdy), 64'd0);
    chk("rst_oval", 64'(ostream_val), 64'd0);
    chk("rst_omsg", ostream_msg, 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_irdy", 64'(istream_rdy), 64'd1);
    txn("7div2", 64'h00000007_00000002, 64'h00000001_00000003, 33);
    txn("m7div2", 64'hFFFFFFF9_00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    txn("7divm2", 64'h00000007_FFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    txn("5div0", 64'h00000005_00000000, 64'h00000005_FFFFFFFF, 1);
    txn("m5div0", 64'hFFFFFFFB_00000000, 64'hFFFFFFFB_FFFFFFFF, 1);
    txn("ovf", 64'h80000000_FFFFFFFF, 64'h00000000_80000000, 33);
    txn("m1divm1", 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 33);
    send(64'h00000064_FFFFFFFD);
    wait_val(lat);
    held = ostream_msg;
    chk("hold_val", held, 64'h00000001_FFFFFFDF);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      stable &= ostream_val && !istream_rdy && (ostream_msg === held);
    end
    chk("hold_stable", 64'(stable), 64'd1);
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
    ostream_rdy = 1'b0;
    chk("release_irdy", 64'(istream_rdy), 64'd1);
    chk("release_oval", 64'(ostream_val), 64'd0);
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      m = {a, b};
      send(m);
      recv(got, lat);
      chk("rand_msg", got, model(m));
      chk("rand_lat", 64'(lat), b == 0 ? 64'd1 : 64'd33);
    end
    send(64'h000003E8_00000003);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_oval", 64'(ostream_val), 64'd0);
    chk("midrst_irdy", 64'(istream_rdy), 64'd1);
    chk("midrst_omsg", ostream_msg, 64'd0);
    txn("100div7", 64'h00000064_00000007, 64'h00000002_0000000E, 33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
